mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 151 +++++++++++++++
 tb/tb_mult_div.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and divider (restoring, on
// magnitudes), one iteration per clock, started by a rising edge of MULT_OP/DIV_OP.
module mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MULT_OP,
  input  logic             DIV_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MultHi,
  output logic [WIDTH-1:0] MultLo,
  output logic [WIDTH-1:0] DivHi,
  output logic [WIDTH-1:0] DivLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        mult_prev_q, div_prev_q, armed_q, is_div_q;
  logic        q_neg_q, r_neg_q;
  logic [4:0]  cnt_q;
  logic [64:0] booth_q;
  logic [31:0] mcand_q, dmag_q, quo_q;
  logic [32:0] rem_q;

  logic        mult_rise, div_rise, start_mult, start_div, idle;
  logic [31:0] a_mag, b_mag, booth_m, quo_in, div_v, quo_d, quo_fix, rem_fix;
  logic [64:0] booth_in, booth_d;
  logic [32:0] rem_in, shifted, trial, rem_d;

  // One Booth step: add/subtract on a 33-bit accumulator so the most negative
  // multiplicand cannot overflow, then arithmetic shift right of {acc,Q,q-1}.
  function automatic logic [64:0] booth_step(input logic [64:0] r, input logic [31:0] m);
    logic [32:0] sum;
    sum = {r[64], r[64:33]};
    case (r[1:0])
      2'b01:   sum = sum + {m[31], m};
      2'b10:   sum = sum - {m[31], m};
      default: sum = sum;
    endcase
    return {sum, r[32:1]};
  endfunction

  // armed_q keeps an op level already high across reset release from looking like a rise.
  assign mult_rise  = MULT_OP & ~mult_prev_q;
  assign div_rise   = DIV_OP & ~div_prev_q;
  assign idle       = (state_q == IDLE);
  assign start_mult = idle & armed_q & mult_rise;
  assign start_div  = idle & armed_q & div_rise & ~mult_rise;

  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = B[31] ? (32'd0 - B) : B;

  // In IDLE the datapaths run iteration 0 straight from the live operands.
  assign booth_in = idle ? {32'd0, B, 1'b0} : booth_q;
  assign booth_m  = idle ? A : mcand_q;
  assign booth_d  = booth_step(booth_in, booth_m);

  assign rem_in  = idle ? 33'd0 : rem_q;
  assign quo_in  = idle ? a_mag : quo_q;
  assign div_v   = idle ? b_mag : dmag_q;
  assign shifted = {rem_in[31:0], quo_in[31]};
  assign trial   = shifted - {1'b0, div_v};
  assign rem_d   = trial[32] ? shifted : trial;
  assign quo_d   = {quo_in[30:0], ~trial[32]};

  assign quo_fix = q_neg_q ? (32'd0 - quo_d) : quo_d;
  assign rem_fix = r_neg_q ? (32'd0 - rem_d[31:0]) : rem_d[31:0];

  assign dbg_state_o = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mult_prev_q <= 1'b0;
      div_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      is_div_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= 5'd0;
      booth_q     <= 65'd0;
      mcand_q     <= 32'd0;
      dmag_q      <= 32'd0;
      quo_q       <= 32'd0;
      rem_q       <= 33'd0;
      MultHi      <= 32'd0;
      MultLo      <= 32'd0;
      DivHi       <= 32'd0;
      DivLo       <= 32'd0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      DivZero     <= 1'b0;
    end else begin
      mult_prev_q <= MULT_OP;
      div_prev_q  <= DIV_OP;
      armed_q     <= 1'b1;
      Done        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_mult || start_div) begin
            is_div_q <= start_div;
            mcand_q  <= A;
            dmag_q   <= b_mag;
            q_neg_q  <= A[31] ^ B[31];
            r_neg_q  <= A[31];
            booth_q  <= booth_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= 5'd0;
            Busy     <= 1'b1;
            state_q  <= RUN;
            if (start_div) DivZero <= (B == 32'd0);
          end
        end
        RUN: begin
          booth_q <= booth_d;
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q + 5'd1;
          // cnt_q == 30 means this edge completes iteration 31.
          if (cnt_q == 5'd30) begin
            state_q <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            if (!is_div_q) begin
              MultHi <= booth_d[64:33];
              MultLo <= booth_d[32:1];
            end else if (!DivZero) begin
              DivLo <= quo_fix;
              DivHi <= rem_fix;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: hand-computed products/quotients, divide-by-zero,
// overflow, held/simultaneous ops, back-to-back starts and mid-run reset.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MULT_OP = 1'b0;
  logic        DIV_OP = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] MultHi, MultLo, DivHi, DivLo;
  logic        Busy, Done, DivZero;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int n, busy1, done_cnt, busy_cnt, first_done;

  mult_div #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .MULT_OP(MULT_OP), .DIV_OP(DIV_OP),
    .A(A), .B(B), .MultHi(MultHi), .MultLo(MultLo), .DivHi(DivHi), .DivLo(DivLo),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .dbg_state_o(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for Done; operands are scrambled while running to show they are ignored.
  task automatic wait_done(output int cycles, output int busy_at_1);
    cycles = 0;
    busy_at_1 = 0;
    while (!Done && cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 1) busy_at_1 = Busy;
      A = $urandom;
      B = $urandom;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    MULT_OP = m;
    DIV_OP = d;
    wait_done(n, busy1);
    chk({tag, "_latency"}, n, 32);
    chk({tag, "_busy_run"}, busy1, 1);
    chk({tag, "_busy_done"}, Busy, 0);
    MULT_OP = 1'b0;
    DIV_OP = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, Done, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_multhi", MultHi, 0);
    chk("rst_multlo", MultLo, 0);
    chk("rst_divhi", DivHi, 0);
    chk("rst_divlo", DivLo, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_divzero", DivZero, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    repeat (2) tick();

    run_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    chk("mul_7x-3_hi", MultHi, 32'hFFFFFFFF);
    chk("mul_7x-3_lo", MultLo, 32'hFFFFFFEB);

    run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    chk("div_-7/2_lo", DivLo, 32'hFFFFFFFD);
    chk("div_-7/2_hi", DivHi, 32'hFFFFFFFF);
    chk("div_-7/2_dz", DivZero, 0);
    chk("div_-7/2_mulhi_kept", MultHi, 32'hFFFFFFFF);

    run_op("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0);
    chk("div_5/0_dz", DivZero, 1);
    chk("div_5/0_lo_kept", DivLo, 32'hFFFFFFFD);
    chk("div_5/0_hi_kept", DivHi, 32'hFFFFFFFF);

    run_op("mul_100x-100", 1'b1, 1'b0, 32'd100, 32'hFFFFFF9C);
    chk("mul_100x-100_hi", MultHi, 32'hFFFFFFFF);
    chk("mul_100x-100_lo", MultLo, 32'hFFFFD8F0);
    chk("mul_dz_kept", DivZero, 1);

    run_op("div_ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", DivLo, 32'h80000000);
    chk("div_ovf_hi", DivHi, 32'd0);
    chk("div_ovf_dz_cleared", DivZero, 0);

    run_op("mul_minxmin", 1'b1, 1'b0, 32'h80000000, 32'h80000000);
    chk("mul_minxmin_hi", MultHi, 32'h40000000);
    chk("mul_minxmin_lo", MultLo, 32'd0);

    run_op("mul_3x5", 1'b1, 1'b0, 32'd3, 32'd5);
    chk("mul_3x5_hi", MultHi, 32'd0);
    chk("mul_3x5_lo", MultLo, 32'd15);

    run_op("div_100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFFFFF9);
    chk("div_100/-7_lo", DivLo, 32'hFFFFFFF2);
    chk("div_100/-7_hi", DivHi, 32'd2);

    // Both ops rise together and stay high: one multiply, no restart.
    A = 32'h00010000;
    B = 32'h00010000;
    MULT_OP = 1'b1;
    DIV_OP = 1'b1;
    done_cnt = 0;
    first_done = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (Done) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
    end
    chk("both_done_count", done_cnt, 1);
    chk("both_done_at", first_done, 32);
    chk("both_multhi", MultHi, 32'd1);
    chk("both_multlo", MultLo, 32'd0);
    chk("both_divlo_kept", DivLo, 32'hFFFFFFF2);
    chk("both_divhi_kept", DivHi, 32'd2);
    MULT_OP = 1'b0;
    DIV_OP = 1'b0;
    tick();

    // Reset after iteration 10 of a divide with DIV_OP held high.
    A = 32'd1000;
    B = 32'd3;
    DIV_OP = 1'b1;
    repeat (11) tick();
    chk("rr_busy_before", Busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rr_busy", Busy, 0);
    chk("rr_done", Done, 0);
    chk("rr_multhi", MultHi, 0);
    chk("rr_multlo", MultLo, 0);
    chk("rr_divhi", DivHi, 0);
    chk("rr_divlo", DivLo, 0);
    chk("rr_state", dbg_state, 0);
    tick();
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
    end
    chk("rr_held_no_done", done_cnt, 0);
    chk("rr_held_no_busy", busy_cnt, 0);
    DIV_OP = 1'b0;
    tick();
    run_op("div_1000/3", 1'b0, 1'b1, 32'd1000, 32'd3);
    chk("div_1000/3_lo", DivLo, 32'd333);
    chk("div_1000/3_hi", DivHi, 32'd1);
    chk("div_1000/3_multlo_zero", MultLo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
